// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port,
// with a pending-write scoreboard for RAW hazard detection at decode.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   alu_* / ld_*        ALU and LSU writeback requests (valid/da/data),
//                       ready = granted this cycle
//   rsv_valid, rsv_da   issue-time reservation of a destination register
//   chk_aa, chk_ba      source addresses looked up in the scoreboard
//   a_busy, b_busy      combinational pending-write lookups
//   RW, DA, D_data      registered register-file write port
//   sb_err              sticky double-reservation flag
//   idle                no pending writes and no write in flight
module regfile_wb_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 32,
  parameter int NREG     = 32,
  parameter bit LD_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_da,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_da,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          rsv_valid,
  input  logic [AW-1:0] rsv_da,
  input  logic [AW-1:0] chk_aa,
  input  logic [AW-1:0] chk_ba,
  output logic          a_busy,
  output logic          b_busy,
  output logic          RW,
  output logic [AW-1:0] DA,
  output logic [DW-1:0] D_data,
  output logic          sb_err,
  output logic          idle
);

  logic            ptr_ld;
  logic [NREG-1:0] busy;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] set_mask;
  logic            alu_gnt;
  logic            ld_gnt;
  logic            clash;

  // Pointer only matters when both requesters are valid.
  always_comb begin
    alu_gnt = alu_valid && (!ld_valid || !ptr_ld);
    ld_gnt  = ld_valid && (!alu_valid || ptr_ld);
  end

  assign alu_ready = alu_gnt;
  assign ld_ready  = ld_gnt;

  // Clear applies first so a same-edge set on the
  // same register leaves the bit high.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (RW)
      clr_mask[DA] = 1'b1;
    if (rsv_valid)
      set_mask[rsv_da] = 1'b1;
  end

  // A register retiring on this very edge may be
  // reserved again without flagging an error.
  assign clash = rsv_valid && busy[rsv_da]
              && !(RW && (DA == rsv_da));

  always_ff @(posedge clk) begin
    if (reset) begin
      RW     <= 1'b0;
      DA     <= '0;
      D_data <= '0;
      busy   <= '0;
      sb_err <= 1'b0;
      ptr_ld <= LD_FIRST;
    end else begin
      busy <= (busy & ~clr_mask) | set_mask;
      if (clash)
        sb_err <= 1'b1;
      RW <= alu_gnt | ld_gnt;
      unique case (1'b1)
        ld_gnt: begin
          DA     <= ld_da;
          D_data <= ld_data;
          ptr_ld <= 1'b0;
        end
        alu_gnt: begin
          DA     <= alu_da;
          D_data <= alu_data;
          ptr_ld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign a_busy = busy[chk_aa];
  assign b_busy = busy[chk_ba];
  assign idle   = ~|busy && !RW;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed
// scenarios followed by randomized traffic against a reference model.
module tb_regfile_wb_arbiter;

  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          alu_valid, ld_valid, rsv_valid;
  logic [AW-1:0] alu_da, ld_da, rsv_da, chk_aa, chk_ba;
  logic [DW-1:0] alu_data, ld_data;
  logic          alu_ready, ld_ready, a_busy, b_busy;
  logic          RW, sb_err, idle;
  logic [AW-1:0] DA;
  logic [DW-1:0] D_data;

  regfile_wb_arbiter #(
    .AW(AW), .DW(DW), .NREG(NREG), .LD_FIRST(1'b1)
  ) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_da(alu_da),
    .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_da(ld_da),
    .ld_data(ld_data), .ld_ready(ld_ready),
    .rsv_valid(rsv_valid), .rsv_da(rsv_da),
    .chk_aa(chk_aa), .chk_ba(chk_ba),
    .a_busy(a_busy), .b_busy(b_busy),
    .RW(RW), .DA(DA), .D_data(D_data),
    .sb_err(sb_err), .idle(idle)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: pending set, last winner, write in flight.
  bit            m_busy [NREG];
  bit            m_err;
  bit            m_rw;
  logic [AW-1:0] m_da;
  logic [DW-1:0] m_data;
  int            m_last;  // 0 none since reset, 1 ALU, 2 LSU
  bit            g_alu, g_ld;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m_busy[i]) m_busy[i] = 1'b0;
    m_err  = 1'b0;
    m_rw   = 1'b0;
    m_da   = '0;
    m_data = '0;
    m_last = 0;
  endtask

  // One clock: check all outputs against the model,
  // advance the model, then move to the next negedge.
  task automatic cycle();
    bit any;
    #1;
    if (alu_valid && ld_valid) begin
      g_ld  = (m_last == 0) ? 1'b1 : (m_last == 1);
      g_alu = !g_ld;
    end else begin
      g_alu = alu_valid;
      g_ld  = ld_valid;
    end
    any = 1'b0;
    foreach (m_busy[i]) any |= m_busy[i];
    chk("alu_ready", alu_ready, g_alu);
    chk("ld_ready", ld_ready, g_ld);
    chk("a_busy", a_busy, m_busy[chk_aa]);
    chk("b_busy", b_busy, m_busy[chk_ba]);
    chk("idle", idle, !any && !m_rw);
    chk("RW", RW, m_rw);
    chk("DA", DA, m_da);
    chk("D_data", D_data, m_data);
    chk("sb_err", sb_err, m_err);
    if (reset) begin
      model_reset();
    end else begin
      if (rsv_valid && m_busy[rsv_da]
          && !(m_rw && m_da == rsv_da))
        m_err = 1'b1;
      if (m_rw) m_busy[m_da] = 1'b0;
      if (rsv_valid) m_busy[rsv_da] = 1'b1;
      m_rw = g_alu || g_ld;
      if (g_ld) begin
        m_da = ld_da; m_data = ld_data; m_last = 2;
      end else if (g_alu) begin
        m_da = alu_da; m_data = alu_data; m_last = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic quiet();
    alu_valid = 0; ld_valid = 0; rsv_valid = 0;
  endtask

  initial begin
    reset = 1; quiet();
    alu_da = 0; alu_data = 0; ld_da = 0; ld_data = 0;
    rsv_da = 0; chk_aa = 0; chk_ba = 0;
    @(posedge clk); @(negedge clk);
    model_reset();
    reset = 0;
    // Reset state
    chk("rst_RW", RW, 0);
    chk("rst_idle", idle, 1);
    chk("rst_sb_err", sb_err, 0);
    cycle();

    // 1: sole ALU request
    alu_valid = 1; alu_da = 3; alu_data = 32'hDEADBEEF;
    #1 chk("t1_alu_ready", alu_ready, 1);
    cycle();
    quiet();
    chk("t1_RW", RW, 1);
    chk("t1_DA", DA, 3);
    chk("t1_D_data", D_data, 32'hDEADBEEF);
    cycle();
    chk("t1_RW_low", RW, 0);

    // 2: contention, alternating grants
    alu_valid = 1; alu_da = 1; alu_data = 32'h1111;
    ld_valid = 1; ld_da = 2; ld_data = 32'h2222;
    for (int i = 0; i < 4; i++) begin
      #1 chk("t2_ld_ready", ld_ready, (i % 2) == 0);
      chk("t2_alu_ready", alu_ready, (i % 2) == 1);
      cycle();
      chk("t2_RW", RW, 1);
      chk("t2_DA", DA, (i % 2 == 0) ? 2 : 1);
    end
    quiet();
    cycle();

    // 3: reservation tracked until the write retires
    rsv_valid = 1; rsv_da = 7; chk_aa = 7;
    cycle();
    rsv_valid = 0;
    chk("t3_busy_a", a_busy, 1);
    chk("t3_not_idle", idle, 0);
    cycle();
    ld_valid = 1; ld_da = 7; ld_data = 32'h77;
    cycle();
    ld_valid = 0;
    chk("t3_DA7", DA, 7);
    chk("t3_busy_b", a_busy, 1);
    cycle();
    chk("t3_free", a_busy, 0);
    chk("t3_idle", idle, 1);

    // 4: same-edge retire/re-reserve, then double reservation
    rsv_valid = 1; rsv_da = 5; chk_aa = 5;
    cycle();
    rsv_valid = 0;
    alu_valid = 1; alu_da = 5; alu_data = 32'h55;
    cycle();
    alu_valid = 0;
    rsv_valid = 1; rsv_da = 5;
    chk("t4_RW", RW, 1);
    cycle();
    rsv_valid = 0;
    chk("t4_busy5", a_busy, 1);
    chk("t4_no_err", sb_err, 0);
    rsv_valid = 1; rsv_da = 5;
    cycle();
    rsv_valid = 0;
    chk("t4_err", sb_err, 1);
    ld_valid = 1; ld_da = 5; ld_data = 32'h9;
    cycle();
    ld_valid = 0;
    cycle();
    cycle();
    chk("t4_err_sticky", sb_err, 1);

    // 5: reset mid-stream
    rsv_valid = 1; rsv_da = 4;
    cycle();
    rsv_da = 9;
    cycle();
    rsv_valid = 0;
    ld_valid = 1; ld_da = 12; ld_data = 32'hC;
    cycle();
    ld_valid = 0;
    chk("t5_RW_pre", RW, 1);
    reset = 1;
    cycle();
    reset = 0;
    chk_aa = 4; chk_ba = 9;
    #1;
    chk("t5_RW", RW, 0);
    chk("t5_a", a_busy, 0);
    chk("t5_b", b_busy, 0);
    chk("t5_err", sb_err, 0);
    chk("t5_idle", idle, 1);
    alu_valid = 1; alu_da = 1; alu_data = 1;
    ld_valid = 1; ld_da = 2; ld_data = 2;
    #1 chk("t5_ld_first", ld_ready, 1);
    cycle();
    quiet();
    cycle();

    // Randomized traffic; ungranted requests are held stable
    for (int n = 0; n < 400; n++) begin
      if (!(alu_valid && !g_alu)) begin
        alu_valid = ($urandom % 3) != 0;
        alu_da    = AW'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!(ld_valid && !g_ld)) begin
        ld_valid = ($urandom % 2) != 0;
        ld_da    = AW'($urandom_range(0, 7));
        ld_data  = $urandom;
      end
      rsv_valid = ($urandom % 4) == 0;
      rsv_da    = AW'($urandom_range(0, 7));
      chk_aa    = AW'($urandom_range(0, 7));
      chk_ba    = AW'($urandom);
      reset     = ($urandom % 60) == 0;
      cycle();
    end
    reset = 0;
    quiet();
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
